// File: rtl/fc_layer_seq_pkg.sv
// fc_pkg: shared state encoding, default fixed-point constants
// and the round/saturate helper for the FC layer engine.
package fc_pkg;

    localparam int FC_DW   = 16;
    localparam int FC_FRAC = 8;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } fc_state_e;

    // Round half up, arithmetic shift, optional ReLU, clip to dw bits.
    function automatic logic [63:0] fc_round_sat(
        input  logic [63:0] acc,
        input  int          frac,
        input  int          dw,
        input  logic        relu,
        output logic        sat
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r   = $signed(acc) + (64'sd1 <<< (frac - 1));
        r   = r >>> frac;
        if (relu && (r < 0)) begin
            r = '0;
        end
        hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (dw - 1));
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// fc_layer_seq_if: bias/fm/weight read ports and result write port.
// master = engine side, slave = memory side.
interface fc_layer_seq_if #(
    parameter int DW       = 16,
    parameter int NUM_OUT  = 10,
    parameter int FM_LANES = 10,
    parameter int AW       = 10
) ();

    logic                     bias_rd_en;
    logic [AW-1:0]            bias_rd_addr;
    logic [NUM_OUT*DW-1:0]    bias_rd_data;
    logic                     fm_rd_en;
    logic [AW-1:0]            fm_rd_addr;
    logic [FM_LANES*DW-1:0]   fm_rd_data;
    logic                     w_rd_en;
    logic [AW-1:0]            w_rd_addr;
    logic [NUM_OUT*DW-1:0]    w_rd_data;
    logic                     out_we;
    logic [AW-1:0]            out_addr;
    logic [DW-1:0]            out_data;

    modport master (
        output bias_rd_en, bias_rd_addr,
        input  bias_rd_data,
        output fm_rd_en, fm_rd_addr,
        input  fm_rd_data,
        output w_rd_en, w_rd_addr,
        input  w_rd_data,
        output out_we, out_addr, out_data
    );

    modport slave (
        input  bias_rd_en, bias_rd_addr,
        output bias_rd_data,
        input  fm_rd_en, fm_rd_addr,
        output fm_rd_data,
        input  w_rd_en, w_rd_addr,
        output w_rd_data,
        input  out_we, out_addr, out_data
    );

endinterface

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one neuron's product register and accumulator.
// Bias load presets acc with the bias aligned to the product scale.
module fc_mac_lane #(
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             bias_ld_i,
    input  logic [DW-1:0]    bias_i,
    input  logic             mul_en_i,
    input  logic [DW-1:0]    x_i,
    input  logic [DW-1:0]    w_i,
    output logic [ACC_W-1:0] acc_o
);

    logic signed [2*DW-1:0] p_q;
    logic signed [2*DW-1:0] p_d;
    logic                   pv_q;
    logic [ACC_W-1:0]       acc_q;
    logic [ACC_W-1:0]       acc_d;

    // Product of this cycle's operands; bias preset or accumulate.
    always_comb begin
        p_d   = (2*DW)'($signed(x_i)) * (2*DW)'($signed(w_i));
        acc_d = acc_q;
        if (bias_ld_i) begin
            acc_d = {{(ACC_W-DW-FRAC){bias_i[DW-1]}},
                     bias_i, {FRAC{1'b0}}};
        end else if (pv_q) begin
            acc_d = acc_q + {{(ACC_W-2*DW){p_q[2*DW-1]}}, p_q};
        end
    end

    // Two-stage multiply-accumulate registers.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            p_q   <= '0;
            pv_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            p_q   <= p_d;
            pv_q  <= mul_en_i;
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequential FC layer (bias, MAC stream, drain, write).
// Build macro FC_RELU_EN clamps negative results to zero.
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int DW       = FC_DW,
    parameter int FRAC     = FC_FRAC,
    parameter int NUM_IN   = 84,
    parameter int NUM_OUT  = 10,
    parameter int FM_LANES = 10,
    parameter int ACC_W    = 40,
    parameter int AW       = 10,
    parameter int RD_LAT   = 1,
    parameter int W_BASE   = 0,
    parameter int B_BASE   = 0,
    parameter int FM_BASE  = 0,
    parameter int OUT_BASE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fc_en,
    output logic          fc_busy,
    output logic          fc_done,
    output logic [7:0]    sat_cnt,
    fc_layer_seq_if.master mem
);

    localparam int CW = 16;
    localparam int LW = (FM_LANES > 1) ? $clog2(FM_LANES) : 1;
    localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

`ifdef FC_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    fc_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [AW-1:0]          fm_q, fm_d;
    logic                   done_q, done_d;
    logic [7:0]             sat_q, sat_d;
    logic                   en_q;
    logic [RD_LAT-1:0]      vld_q;
    logic [LW-1:0]          lsel_q [RD_LAT];
    logic [FM_LANES*DW-1:0] hold_q;
    logic                   issue;
    logic                   bias_ld;
    logic                   mul_vld;
    logic [LW-1:0]          mul_lane;
    logic [FM_LANES*DW-1:0] fm_word;
    logic [DW-1:0]          x_sel;
    logic [ACC_W-1:0]       acc [NUM_OUT];
    logic [OW-1:0]          osel;
    logic [63:0]            res;
    logic                   res_sat;

    assign issue    = (state_q == MAC);
    assign bias_ld  = fc_en && (state_q == BIAS)
                      && (cnt_q == CW'(RD_LAT));
    assign mul_vld  = vld_q[RD_LAT-1];
    assign mul_lane = lsel_q[RD_LAT-1];
    assign fm_word  = (mul_lane == '0) ? mem.fm_rd_data : hold_q;
    assign x_sel    = fm_word[mul_lane*DW +: DW];
    assign osel     = cnt_q[OW-1:0];

    // FSM state and run bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            fm_q    <= '0;
            done_q  <= 1'b0;
            sat_q   <= '0;
            en_q    <= fc_en;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            fm_q    <= fm_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            en_q    <= fc_en;
        end
    end

    // Lane index travels with the read data; fm word held for reuse.
    always_ff @(posedge clk) begin
        if (rst || !fc_en) begin
            vld_q  <= '0;
            hold_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                lsel_q[k] <= '0;
            end
        end else begin
            vld_q[0]  <= issue;
            lsel_q[0] <= lane_q;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k]  <= vld_q[k-1];
                lsel_q[k] <= lsel_q[k-1];
            end
            if (mul_vld && (mul_lane == '0)) begin
                hold_q <= mem.fm_rd_data;
            end
        end
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_lane
        fc_mac_lane #(
            .DW    (DW),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clr_i     (!fc_en),
            .bias_ld_i (bias_ld),
            .bias_i    (mem.bias_rd_data[j*DW +: DW]),
            .mul_en_i  (mul_vld),
            .x_i       (x_sel),
            .w_i       (mem.w_rd_data[j*DW +: DW]),
            .acc_o     (acc[j])
        );
    end

    // Round and clip the accumulator selected by the write counter.
    always_comb begin
        res_sat = 1'b0;
        res = fc_round_sat(
            {{(64-ACC_W){acc[osel][ACC_W-1]}}, acc[osel]},
            FRAC, DW, RELU, res_sat);
    end

    // Next-state and strobe/address decode.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        lane_d           = lane_q;
        fm_d             = fm_q;
        done_d           = done_q;
        sat_d            = sat_q;
        mem.bias_rd_en   = 1'b0;
        mem.bias_rd_addr = '0;
        mem.fm_rd_en     = 1'b0;
        mem.fm_rd_addr   = '0;
        mem.w_rd_en      = 1'b0;
        mem.w_rd_addr    = '0;
        mem.out_we       = 1'b0;
        mem.out_addr     = '0;
        mem.out_data     = '0;
        if (!fc_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            lane_d  = '0;
            fm_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!en_q) begin
                        state_d = BIAS;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        sat_d   = '0;
                    end
                end
                BIAS: begin
                    if (cnt_q == '0) begin
                        mem.bias_rd_en   = 1'b1;
                        mem.bias_rd_addr = AW'(B_BASE);
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(RD_LAT)) begin
                        state_d = MAC;
                        cnt_d   = '0;
                        lane_d  = '0;
                        fm_d    = '0;
                    end
                end
                MAC: begin
                    mem.w_rd_en   = 1'b1;
                    mem.w_rd_addr = AW'(W_BASE) + AW'(cnt_q);
                    if (lane_q == '0) begin
                        mem.fm_rd_en   = 1'b1;
                        mem.fm_rd_addr = AW'(FM_BASE) + fm_q;
                    end
                    if (lane_q == LW'(FM_LANES - 1)) begin
                        lane_d = '0;
                        fm_d   = fm_q + 1'b1;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(NUM_IN - 1)) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
                DRAIN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(RD_LAT + 1)) begin
                        state_d = WRITE;
                        cnt_d   = '0;
                    end
                end
                WRITE: begin
                    mem.out_we   = 1'b1;
                    mem.out_addr = AW'(OUT_BASE) + AW'(cnt_q);
                    mem.out_data = res[DW-1:0];
                    if (res_sat && (sat_q != 8'hFF)) begin
                        sat_d = sat_q + 8'd1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(NUM_OUT - 1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign fc_busy = (state_q != IDLE) && (state_q != DONE);
    assign fc_done = done_q;
    assign sat_cnt = sat_q;

endmodule
